// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared synth types: envelope FSM state encoding
package synth_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/env_scaler.sv
// rtl/env_scaler.sv - centre/multiply/shift of one wave sample by the envelope, registered
//   clk, rst (async active-low), ena (sample strobe), sample_in [N], env [ENV_W]
//   sample_out [N] registered enveloped sample, out_valid 1-clk pulse after ena
module env_scaler #(
    parameter int N     = 8,
    parameter int ENV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [N-1:0]     sample_in,
    input  logic [ENV_W-1:0] env,
    output logic [N-1:0]     sample_out,
    output logic             out_valid
);

    localparam logic [N-1:0]                MID   = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N+ENV_W:0]     MID_P = (N+ENV_W+1)'(1) << (N-1);

    logic signed [N:0]       d;
    logic signed [N+ENV_W:0] p;
    logic [N-1:0]            sample_out_d, sample_out_q;
    logic                    out_valid_d, out_valid_q;

    always_comb begin
        d = $signed({1'b0, sample_in} - {1'b0, MID});
        // env is unsigned, so zero-extend it before the signed multiply
        p = $signed({{ENV_W{d[N]}}, d}) * $signed({{(N+1){1'b0}}, env});
        // the arithmetic shift floors toward -inf; the result always fits in N bits
        sample_out_d = ena ? N'(MID_P + (p >>> ENV_W)) : sample_out_q;
        out_valid_d  = ena;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_out_q <= MID;
            out_valid_q  <= 1'b0;
        end else begin
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;

endmodule

// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - gate-driven ADSR amplitude envelope applied to one wave sample
//   clk, rst (async active-low), ena (sample strobe), gate (note on/off)
//   sample_in [N], attack_step/decay_step/sustain_level/release_step [ENV_W]
//   sample_out [N] registered, env [ENV_W], out_valid pulse, busy (state != IDLE)
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int N     = 8,
    parameter int ENV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             gate,
    input  logic [N-1:0]     sample_in,
    input  logic [ENV_W-1:0] attack_step,
    input  logic [ENV_W-1:0] decay_step,
    input  logic [ENV_W-1:0] sustain_level,
    input  logic [ENV_W-1:0] release_step,
    output logic [N-1:0]     sample_out,
    output logic [ENV_W-1:0] env,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [ENV_W:0] ENV_MAX_W = {1'b0, {ENV_W{1'b1}}};

    logic             gate_q;
    env_state_t       state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic             rise, fall;
    logic [ENV_W:0]   att_sum;
    logic [ENV_W-1:0] dec_val;

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        att_sum = {1'b0, env_q} + {1'b0, attack_step};
        dec_val = env_q - decay_step;

        // Gate edges only move the FSM; env keeps its value so a retrigger
        // continues from the current level instead of clicking back to 0.
        if (rise) begin
            state_d = ENV_ATTACK;
        end else if (fall) begin
            if (state_q == ENV_ATTACK || state_q == ENV_DECAY || state_q == ENV_SUSTAIN)
                state_d = ENV_RELEASE;
        end else if (ena) begin
            case (state_q)
                ENV_ATTACK: begin
                    if (attack_step == '0 || att_sum >= ENV_MAX_W) begin
                        env_d   = '1;
                        state_d = ENV_DECAY;
                    end else begin
                        env_d = att_sum[ENV_W-1:0];
                    end
                end
                ENV_DECAY: begin
                    // decay_step >= env_q guards dec_val against wrap-around
                    if (decay_step == '0 || env_q <= sustain_level ||
                        decay_step >= env_q || dec_val <= sustain_level) begin
                        env_d   = sustain_level;
                        state_d = ENV_SUSTAIN;
                    end else begin
                        env_d = dec_val;
                    end
                end
                ENV_SUSTAIN: begin
                    env_d = sustain_level;
                end
                ENV_RELEASE: begin
                    if (release_step == '0 || env_q <= release_step) begin
                        env_d   = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        env_d = env_q - release_step;
                    end
                end
                default: begin
                    env_d = env_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_q  <= 1'b0;
            state_q <= ENV_IDLE;
            env_q   <= '0;
        end else begin
            gate_q  <= gate;
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    // Scaler sees env before this ena's update
    env_scaler #(
        .N     (N),
        .ENV_W (ENV_W)
    ) u_env_scaler (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .sample_in  (sample_in),
        .env        (env_q),
        .sample_out (sample_out),
        .out_valid  (out_valid)
    );

    assign env  = env_q;
    assign busy = (state_q != ENV_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - directed self-checking bench for adsr_envelope
module tb_adsr_envelope;
    import synth_pkg::*;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       gate;
    logic [7:0] sample_in;
    logic [7:0] attack_step;
    logic [7:0] decay_step;
    logic [7:0] sustain_level;
    logic [7:0] release_step;
    logic [7:0] sample_out;
    logic [7:0] env;
    logic       out_valid;
    logic       busy;

    int n_pass;
    int n_total;

    adsr_envelope #(.N(8), .ENV_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .gate          (gate),
        .sample_in     (sample_in),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .sample_out    (sample_out),
        .env           (env),
        .out_valid     (out_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int scale(input int s, input int e);
        return 128 + (((s - 128) * e) >>> 8);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single-clock ena strobe; leaves time at #1 after the sampling edge
    task automatic pulse();
        ena = 1'b1;
        cyc();
        ena = 1'b0;
    endtask

    task automatic gap();
        repeat (3) cyc();
    endtask

    // ena strobe with env/out checks; prev is env before the strobe
    task automatic step_chk(input string tag, input int prev, input int exp_env);
        pulse();
        chk({tag, "_env"}, 32'(env), 32'(exp_env));
        chk({tag, "_out"}, 32'(sample_out), 32'(scale(int'(sample_in), prev)));
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        gap();
    endtask

    initial begin
        int envs2 [7];
        int envs3 [4];
        int prev;
        n_pass  = 0;
        n_total = 0;
        rst = 1'b0; ena = 1'b0; gate = 1'b0; sample_in = 8'd128;
        attack_step = 8'd64; decay_step = 8'd32; sustain_level = 8'd160; release_step = 8'd50;
        repeat (3) cyc();
        chk("rst_env", 32'(env), 32'd0);
        chk("rst_out", 32'(sample_out), 32'd128);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        cyc();

        // Attack -> decay -> sustain
        sample_in = 8'd255;
        gate = 1'b1;
        cyc();
        chk("att_edge_state", 32'(dut.state_q), 32'(ENV_ATTACK));
        chk("att_edge_env", 32'(env), 32'd0);
        chk("att_busy", 32'(busy), 32'd1);
        envs2 = '{64, 128, 192, 255, 223, 191, 160};
        prev = 0;
        for (int i = 0; i < 7; i++) begin
            ena = 1'b1;
            cyc();
            ena = 1'b0;
            chk($sformatf("ads_env%0d", i), 32'(env), 32'(envs2[i]));
            chk($sformatf("ads_out%0d", i), 32'(sample_out), 32'(scale(255, prev)));
            if (i == 3) chk("ads_decay_state", 32'(dut.state_q), 32'(ENV_DECAY));
            cyc();
            chk($sformatf("ads_vld_drop%0d", i), 32'(out_valid), 32'd0);
            repeat (2) cyc();
            prev = envs2[i];
        end
        chk("sus_state", 32'(dut.state_q), 32'(ENV_SUSTAIN));
        chk("sus_busy", 32'(busy), 32'd1);

        // Release to idle
        gate = 1'b0;
        cyc();
        chk("rel_edge_state", 32'(dut.state_q), 32'(ENV_RELEASE));
        chk("rel_edge_env", 32'(env), 32'd160);
        envs3 = '{110, 60, 10, 0};
        prev = 160;
        for (int i = 0; i < 4; i++) begin
            step_chk($sformatf("rel%0d", i), prev, envs3[i]);
            prev = envs3[i];
        end
        chk("rel_idle_state", 32'(dut.state_q), 32'(ENV_IDLE));
        chk("rel_idle_busy", 32'(busy), 32'd0);
        step_chk("env0_scale", 0, 0);
        chk("env0_out128", 32'(sample_out), 32'd128);

        // Climb to sustain 160 with zero steps, then release to env 60
        attack_step = 8'd0; decay_step = 8'd0;
        gate = 1'b1;
        cyc();
        step_chk("z_att", 0, 255);
        step_chk("z_dec", 255, 160);
        gate = 1'b0;
        cyc();
        step_chk("r5a", 160, 110);
        step_chk("r5b", 110, 60);

        // Retrigger on the same clk as ena: state only, env held
        attack_step = 8'd64;
        gate = 1'b1;
        ena  = 1'b1;
        cyc();
        ena  = 1'b0;
        chk("retrig_state", 32'(dut.state_q), 32'(ENV_ATTACK));
        chk("retrig_env", 32'(env), 32'd60);
        gap();
        step_chk("retrig_next", 60, 124);

        // Zero steps from ATTACK with sustain at full scale
        attack_step = 8'd0; decay_step = 8'd0; sustain_level = 8'd255;
        step_chk("z6_att", 124, 255);
        chk("z6_decay_state", 32'(dut.state_q), 32'(ENV_DECAY));
        step_chk("z6_dec", 255, 255);
        chk("z6_sus_state", 32'(dut.state_q), 32'(ENV_SUSTAIN));

        // Scaling at env=255
        sample_in = 8'd255;
        step_chk("sc255", 255, 255);
        chk("sc255_val", 32'(sample_out), 32'd254);
        sample_in = 8'd0;
        step_chk("sc0", 255, 255);
        chk("sc0_val", 32'(sample_out), 32'd0);
        sample_in = 8'd128;
        step_chk("sc128", 255, 255);
        chk("sc128_val", 32'(sample_out), 32'd128);

        // Live sustain level tracking
        sustain_level = 8'd100;
        step_chk("sus_live", 255, 100);

        // Get to ATTACK env=128, then reset asynchronously mid-cycle
        gate = 1'b0; release_step = 8'd0;
        cyc();
        step_chk("r0", 100, 0);
        attack_step = 8'd64; sample_in = 8'd200;
        gate = 1'b1;
        cyc();
        step_chk("a1", 0, 64);
        pulse();
        chk("a2_env", 32'(env), 32'd128);
        chk("a2_vld", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_env", 32'(env), 32'd0);
        chk("arst_state", 32'(dut.state_q), 32'(ENV_IDLE));
        chk("arst_out", 32'(sample_out), 32'd128);
        chk("arst_vld", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
